// File: rtl/apb_master_fsm.sv
`default_nettype none
// ============================================================================
// Module      : apb_master_fsm
// Description : AHB-to-APB bridge master state machine. Turns AHB transfers
//               into APB setup/enable cycles, supports pipelined back-to-back
//               writes, and times out slaves that hold Pready low too long.
// Revision    : 1.0 - initial release
// ============================================================================
module apb_master_fsm #(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int NSLV     = 3,
  parameter int WAIT_MAX = 15
) (
  input  logic              Hclk,
  input  logic              Hreset,
  input  logic              valid,
  input  logic              Hwrite,
  input  logic              Hwritereg,
  input  logic [ADDR_W-1:0] Haddr,
  input  logic [ADDR_W-1:0] Haddr1,
  input  logic [DATA_W-1:0] Hwdata,
  input  logic [DATA_W-1:0] Hwdata1,
  input  logic [NSLV-1:0]   tempselx,
  input  logic [DATA_W-1:0] Prdata,
  input  logic              Pready,
  input  logic              Pslverr,
  output logic [NSLV-1:0]   Pselx,
  output logic              Penable,
  output logic              Pwrite,
  output logic [ADDR_W-1:0] Paddr,
  output logic [DATA_W-1:0] Pwdata,
  output logic              Hreadyout,
  output logic [DATA_W-1:0] Hrdata,
  output logic              Hresp
);

  localparam int              CNT_W    = (WAIT_MAX < 1) ? 1 : $clog2(WAIT_MAX + 1);
  localparam logic [CNT_W-1:0] WAIT_LIM = CNT_W'(WAIT_MAX);

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_READ     = 3'd1;
  localparam logic [2:0] ST_RENABLE  = 3'd2;
  localparam logic [2:0] ST_WWAIT    = 3'd3;
  localparam logic [2:0] ST_WRITE    = 3'd4;
  localparam logic [2:0] ST_WENABLE  = 3'd5;
  localparam logic [2:0] ST_WRITEP   = 3'd6;
  localparam logic [2:0] ST_WENABLEP = 3'd7;

  logic [2:0]        state_q, state_d;
  logic [NSLV-1:0]   pselx_q;
  logic              penable_q;
  logic              pwrite_q;
  logic [ADDR_W-1:0] paddr_q;
  logic [DATA_W-1:0] pwdata_q;
  logic [DATA_W-1:0] hrdata_q;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic       w_in_enable;
  logic       w_timeout;
  logic       w_done;
  logic [2:0] w_decode;

  // Write data is taken from Hwdata during the data phase, so the pipelined
  // copy is not needed by this bridge.
  logic unused_hwdata1;
  assign unused_hwdata1 = ^Hwdata1;

  assign w_in_enable = (state_q == ST_RENABLE) || (state_q == ST_WENABLE) ||
                       (state_q == ST_WENABLEP);
  // A slave that keeps Pready low for WAIT_MAX waits is cut off on the next cycle.
  assign w_timeout   = w_in_enable && !Pready && (cnt_q == WAIT_LIM);
  assign w_done      = w_in_enable && (Pready || w_timeout);
  assign w_decode    = !valid ? ST_IDLE : (Hwrite ? ST_WWAIT : ST_READ);

  // AHB response is driven straight from the completing enable cycle.
  assign Hreadyout = (state_q == ST_IDLE) || (state_q == ST_WWAIT) || w_done;
  assign Hresp     = w_in_enable && ((Pready && Pslverr) || w_timeout);

  assign Pselx   = pselx_q;
  assign Penable = penable_q;
  assign Pwrite  = pwrite_q;
  assign Paddr   = paddr_q;
  assign Pwdata  = pwdata_q;
  assign Hrdata  = hrdata_q;

  // Next-state decode.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:     state_d = w_decode;
      ST_READ:     state_d = ST_RENABLE;
      ST_RENABLE:  if (w_done) state_d = w_decode;
      ST_WWAIT:    state_d = valid ? ST_WRITEP : ST_WRITE;
      ST_WRITE:    state_d = ST_WENABLE;
      ST_WRITEP:   state_d = ST_WENABLEP;
      ST_WENABLE:  if (w_done) state_d = w_decode;
      ST_WENABLEP: if (w_done) state_d = !Hwritereg ? ST_READ :
                                         (valid ? ST_WRITEP : ST_WRITE);
      default:     state_d = ST_IDLE;
    endcase
  end

  // Wait counter runs only while an enable cycle is stalled; any other cycle clears it.
  always_comb begin
    cnt_d = '0;
    if (w_in_enable && !w_done) cnt_d = cnt_q + CNT_W'(1);
  end

  // State and wait-counter registers.
  always_ff @(posedge Hclk) begin
    if (Hreset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // APB request registers: loaded on entry to a setup state, held through enable.
  always_ff @(posedge Hclk) begin
    if (Hreset) begin
      pselx_q   <= '0;
      penable_q <= 1'b0;
      pwrite_q  <= 1'b0;
      paddr_q   <= '0;
      pwdata_q  <= '0;
    end else begin
      case (state_d)
        ST_READ: begin
          pselx_q   <= tempselx;
          paddr_q   <= Haddr;
          pwrite_q  <= 1'b0;
          penable_q <= 1'b0;
        end
        ST_WRITE, ST_WRITEP: begin
          pselx_q   <= tempselx;
          paddr_q   <= Haddr1;
          pwdata_q  <= Hwdata;
          pwrite_q  <= 1'b1;
          penable_q <= 1'b0;
        end
        ST_RENABLE, ST_WENABLE, ST_WENABLEP: begin
          penable_q <= 1'b1;
        end
        default: begin
          pselx_q   <= '0;
          penable_q <= 1'b0;
        end
      endcase
    end
  end

  // Read data is captured whenever a read enable cycle sees Pready, error or not.
  always_ff @(posedge Hclk) begin
    if (Hreset) begin
      hrdata_q <= '0;
    end else if ((state_q == ST_RENABLE) && Pready) begin
      hrdata_q <= Prdata;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_apb_master_fsm.sv
`default_nettype none
// ============================================================================
// Module      : tb_apb_master_fsm
// Description : Self-checking bench for apb_master_fsm. Transfers are expanded
//               into per-cycle input/expectation records from the bus rules,
//               then replayed and compared every cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_apb_master_fsm;

  localparam int WAIT_MAX = 15;

  logic        Hclk = 1'b0;
  logic        Hreset, valid, Hwrite, Hwritereg, Pready, Pslverr;
  logic [31:0] Haddr, Haddr1, Hwdata, Hwdata1, Prdata;
  logic [2:0]  tempselx, Pselx;
  logic        Penable, Pwrite, Hreadyout, Hresp;
  logic [31:0] Paddr, Pwdata, Hrdata;

  apb_master_fsm #(
    .ADDR_W(32), .DATA_W(32), .NSLV(3), .WAIT_MAX(WAIT_MAX)
  ) dut (
    .Hclk(Hclk), .Hreset(Hreset), .valid(valid), .Hwrite(Hwrite),
    .Hwritereg(Hwritereg), .Haddr(Haddr), .Haddr1(Haddr1), .Hwdata(Hwdata),
    .Hwdata1(Hwdata1), .tempselx(tempselx), .Prdata(Prdata), .Pready(Pready),
    .Pslverr(Pslverr), .Pselx(Pselx), .Penable(Penable), .Pwrite(Pwrite),
    .Paddr(Paddr), .Pwdata(Pwdata), .Hreadyout(Hreadyout), .Hrdata(Hrdata),
    .Hresp(Hresp)
  );

  always #5 Hclk = ~Hclk;

  // One bus cycle: inputs to drive and outputs the bus rules demand.
  typedef struct {
    logic        rst, valid, hwrite, hwritereg, pready, pslverr;
    logic [31:0] haddr, haddr1, hwdata, prdata;
    logic [2:0]  tsel;
    logic        chk, full, act;
    logic [2:0]  x_sel;
    logic        x_en, x_wr, x_hready, x_hresp;
    logic [31:0] x_addr, x_wdata, x_hrdata;
    int          tag;
  } cyc_t;

  cyc_t        q[$];
  cyc_t        cur;
  bit          cur_v = 1'b0;
  int          errors = 0;
  int          checks = 0;
  int          run0 = 0;
  logic [31:0] m_hrdata = 32'h0;

  // Idle bus cycle; Pready/Pslverr high to show they are ignored outside enable.
  function automatic cyc_t blank();
    cyc_t c;
    c.rst = 0; c.valid = 0; c.hwrite = 0; c.hwritereg = 0; c.pready = 1; c.pslverr = 1;
    c.haddr = 0; c.haddr1 = 0; c.hwdata = 0; c.prdata = 32'h5A5A_5A5A; c.tsel = 0;
    c.chk = 1; c.full = 0; c.act = 0; c.x_sel = 0; c.x_en = 0; c.x_wr = 0;
    c.x_hready = 1; c.x_hresp = 0; c.x_addr = 0; c.x_wdata = 0; c.x_hrdata = m_hrdata;
    c.tag = 0;
    return c;
  endfunction

  function automatic cyc_t wbase(input logic [31:0] a, input logic [31:0] d, input logic [2:0] s);
    cyc_t c;
    c = blank();
    c.hwritereg = 1; c.haddr1 = a; c.hwdata = d; c.tsel = s;
    c.act = 1; c.x_sel = s; c.x_addr = a; c.x_wdata = d; c.x_wr = 1;
    return c;
  endfunction

  task automatic gen_idle(input int n, input int tag);
    cyc_t c;
    for (int i = 0; i < n; i++) begin
      c = blank(); c.tag = tag; q.push_back(c);
    end
  endtask

  // mode: 0 ok, 1 slave error, 2 timeout, 3 reset during first enable cycle
  task automatic gen_read(input logic [31:0] a, input logic [2:0] s, input logic [31:0] d,
                          input int waits, input int mode);
    cyc_t c;
    int   nw;
    c = blank(); c.valid = 1; c.haddr = a; c.tsel = s; q.push_back(c);
    c = blank(); c.haddr = a; c.tsel = s; c.act = 1; c.x_sel = s; c.x_addr = a;
    c.x_hready = 0; q.push_back(c);
    if (mode == 3) begin
      c = blank(); c.rst = 1; c.tsel = s; c.pready = 0; c.act = 1; c.x_sel = s;
      c.x_addr = a; c.x_en = 1; c.x_hready = 0; q.push_back(c);
      m_hrdata = 32'h0;
      c = blank(); c.full = 1; c.tag = 5; q.push_back(c);
      return;
    end
    nw = (mode == 2) ? WAIT_MAX : waits;
    for (int i = 0; i < nw; i++) begin
      c = blank(); c.tsel = s; c.pready = 0; c.prdata = 32'hBAD0_0000 | 32'(i);
      c.act = 1; c.x_sel = s; c.x_addr = a; c.x_en = 1; c.x_hready = 0; q.push_back(c);
    end
    c = blank(); c.tsel = s; c.pready = (mode != 2); c.pslverr = (mode == 1); c.prdata = d;
    c.act = 1; c.x_sel = s; c.x_addr = a; c.x_en = 1; c.x_hready = 1; c.x_hresp = (mode != 0);
    q.push_back(c);
    if (mode != 2) m_hrdata = d;
  endtask

  task automatic gen_write(input logic [31:0] a, input logic [31:0] d, input logic [2:0] s,
                           input int waits, input logic err);
    cyc_t c;
    c = blank(); c.valid = 1; c.hwrite = 1; c.haddr = a; c.tsel = s; q.push_back(c);
    c = blank(); c.hwritereg = 1; c.haddr1 = a; c.hwdata = d; c.tsel = s; q.push_back(c);
    c = wbase(a, d, s); c.x_hready = 0; q.push_back(c);
    for (int i = 0; i < waits; i++) begin
      c = wbase(a, d, s); c.pready = 0; c.x_en = 1; c.x_hready = 0; q.push_back(c);
    end
    c = wbase(a, d, s); c.pready = 1; c.pslverr = err; c.x_en = 1; c.x_hready = 1;
    c.x_hresp = err; q.push_back(c);
  endtask

  // n pipelined writes (n >= 2): all but the last ride WRITEP/WENABLEP.
  task automatic gen_burst(input logic [31:0] base, input logic [2:0] s, input int n);
    cyc_t c;
    logic [31:0] a[8];
    logic [31:0] d[8];
    for (int i = 0; i < 8; i++) begin
      a[i] = base + 32'(16 * i);
      d[i] = 32'hB000_0000 + 32'(i);
    end
    c = blank(); c.valid = 1; c.hwrite = 1; c.haddr = a[0]; c.tsel = s; q.push_back(c);
    c = blank(); c.valid = 1; c.hwrite = 1; c.haddr = a[1]; c.hwritereg = 1;
    c.haddr1 = a[0]; c.hwdata = d[0]; c.tsel = s; q.push_back(c);
    for (int i = 0; i < n - 1; i++) begin
      c = wbase(a[i], d[i], s); c.x_hready = 0; q.push_back(c);
      c = wbase(a[i], d[i], s); c.haddr1 = a[i+1]; c.hwdata = d[i+1];
      c.valid = (i < n - 2); c.hwrite = 1; c.haddr = a[i+2];
      c.pready = 1; c.pslverr = 0; c.x_en = 1; c.x_hready = 1; q.push_back(c);
    end
    c = wbase(a[n-1], d[n-1], s); c.x_hready = 0; q.push_back(c);
    c = wbase(a[n-1], d[n-1], s); c.pready = 1; c.pslverr = 0; c.x_en = 1;
    c.x_hready = 1; q.push_back(c);
  endtask

  task automatic apply(input cyc_t c);
    Hreset = c.rst; valid = c.valid; Hwrite = c.hwrite; Hwritereg = c.hwritereg;
    Haddr = c.haddr; Haddr1 = c.haddr1; Hwdata = c.hwdata; Hwdata1 = ~c.hwdata;
    tempselx = c.tsel; Prdata = c.prdata; Pready = c.pready; Pslverr = c.pslverr;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @%0t: got %h expected %h", nm, $time, act, exp);
    end
  endtask

  // Compare process: DUT outputs against the current record, mid-cycle.
  always @(negedge Hclk) begin
    if (cur_v && cur.chk) begin
      chk("Pselx", 32'(Pselx), 32'(cur.x_sel));
      chk("Penable", 32'(Penable), 32'(cur.x_en));
      chk("Hreadyout", 32'(Hreadyout), 32'(cur.x_hready));
      chk("Hresp", 32'(Hresp), 32'(cur.x_hresp));
      chk("Hrdata", Hrdata, cur.x_hrdata);
      if (cur.act || cur.full) begin
        chk("Pwrite", 32'(Pwrite), 32'(cur.x_wr));
        chk("Paddr", Paddr, cur.x_addr);
      end
      if ((cur.act && cur.x_wr) || cur.full) chk("Pwdata", Pwdata, cur.x_wdata);
      case (cur.tag)
        1: begin
          chk("lit_wr_sel", 32'(Pselx), 32'h2);
          chk("lit_wr_addr", Paddr, 32'h10);
          chk("lit_wr_data", Pwdata, 32'hA5);
          chk("lit_wr_pwrite", 32'(Pwrite), 32'h1);
          chk("lit_wr_penable", 32'(Penable), 32'h0);
        end
        2: chk("lit_rd_data", Hrdata, 32'hDEADBEEF);
        3: chk("lit_rd_stall", 32'(run0), 32'd3);
        4: begin
          chk("lit_to_stall", 32'(run0), 32'd16);
          chk("lit_to_hresp", 32'(Hresp), 32'h1);
        end
        5: begin
          chk("lit_rst_hrdata", Hrdata, 32'h0);
          chk("lit_rst_paddr", Paddr, 32'h0);
          chk("lit_rst_hready", 32'(Hreadyout), 32'h1);
        end
        default: ;
      endcase
    end
    if (cur_v) run0 = (Hreadyout === 1'b0) ? run0 + 1 : 0;
  end

  initial begin
    cyc_t c;
    int   s;
    Hreset = 1; valid = 0; Hwrite = 0; Hwritereg = 0; Haddr = 0; Haddr1 = 0;
    Hwdata = 0; Hwdata1 = 0; tempselx = 0; Prdata = 0; Pready = 0; Pslverr = 0;

    // Reset state
    c = blank(); c.rst = 1; c.full = 1; q.push_back(c);
    c = blank(); c.rst = 1; c.full = 1; q.push_back(c);
    gen_idle(2, 0);
    // Single write, literal setup-cycle pin
    s = q.size();
    gen_write(32'h10, 32'hA5, 3'b010, 0, 1'b0);
    c = q[s + 2]; c.tag = 1; q[s + 2] = c;
    gen_idle(1, 0);
    // Read with two Pready waits
    gen_read(32'h20, 3'b001, 32'hDEADBEEF, 2, 0);
    c = q.pop_back(); c.tag = 3; q.push_back(c);
    gen_idle(1, 2);
    // Write stalled three cycles
    gen_write(32'h44, 32'h1234_5678, 3'b100, 3, 1'b0);
    // Back-to-back pipelined writes
    gen_burst(32'h100, 3'b001, 3);
    gen_idle(1, 0);
    // Timeout read
    gen_read(32'h30, 3'b100, 32'h1111_2222, 0, 2);
    c = q.pop_back(); c.tag = 4; q.push_back(c);
    gen_idle(1, 0);
    // Read with slave error still captures data
    gen_read(32'h34, 3'b010, 32'h0BAD_F00D, 1, 1);
    gen_idle(1, 0);
    // Write error, then reset in the middle of a read enable
    gen_write(32'h50, 32'h77, 3'b010, 0, 1'b1);
    gen_read(32'h54, 3'b001, 32'h0, 0, 3);
    // Transfer right after reset, then an unselected read
    gen_read(32'h60, 3'b001, 32'hCAFE_0001, 0, 0);
    gen_read(32'h70, 3'b000, 32'h600D_0001, 1, 0);
    gen_idle(2, 0);

    for (int i = 0; i < q.size(); i++) begin
      @(posedge Hclk);
      #1;
      apply(q[i]);
      cur   = q[i];
      cur_v = 1'b1;
    end
    @(posedge Hclk);
    #1;
    cur_v = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
